// File: rtl/defog_pkg.sv
// Shared types and widths for the defog datapath stages.
// The sync bundle travels alongside pixel data wherever stages need realignment.
package defog_pkg;
  localparam int PIX_W       = 8;
  localparam int DIV_LAT_DEF = 8;
  localparam int MAG_W       = 12;
  localparam int CLIP_CNT_W  = 16;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sign;
  } sync_t;
endpackage

// File: rtl/defog_sync_delay.sv
// Fixed-depth shift register for the sync bundle, DEPTH cycles of latency.
// Free-running with no stall; cleared asynchronously by nrst.
module defog_sync_delay
  import defog_pkg::*;
#(
  parameter int DEPTH = DIV_LAT_DEF
) (
  input  logic  clk,
  input  logic  nrst,
  input  sync_t sync_i,
  output sync_t sync_o
);

  sync_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= sync_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[DEPTH-1];

endmodule

// File: rtl/defog_recover.sv
// Scene-radiance recovery: A +/- rescaled divider quotient, clamped to 8 bits; DIV_LAT+2 cycles, no backpressure.
// DEFOG_RECOVER_STAT_EN adds a per-frame clipped-pixel counter on clip_frame/clip_vld.
module defog_recover
  import defog_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int QMUL    = 255,
  parameter int QSHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_de,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_sign,
  input  logic [PIX_W-1:0]      atmo,
  input  logic [PIX_W-1:0]      quotient,
  output logic [PIX_W-1:0]      out_pix,
  output logic                  out_de,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic [CLIP_CNT_W-1:0] clip_frame,
  output logic                  clip_vld
);

  sync_t in_sync;
  sync_t d_sync;

  assign in_sync = {in_de, in_hsync, in_vsync, in_sign};

  defog_sync_delay #(.DEPTH(DIV_LAT)) u_sync_delay (
    .clk    (clk),
    .nrst   (nrst),
    .sync_i (in_sync),
    .sync_o (d_sync)
  );

  logic             fe;
  logic             d_vs_prev_q;
  logic [PIX_W-1:0] atmo_q;
  logic             a_ok_q;
  logic [15:0]      prod;
  logic [15:0]      scaled;
  logic [MAG_W-1:0] mag_d;
  sync_t            s1_sync_q;
  logic [MAG_W-1:0] s1_mag_q;

  assign fe = d_sync.vs & ~d_vs_prev_q;

  always_comb begin
    prod   = 16'(quotient) * 16'(QMUL);
    scaled = prod >> QSHIFT;
    mag_d  = scaled[MAG_W-1:0];
    if (scaled[15:MAG_W] != '0) mag_d = '1;
  end

  // A is latched on the S1 edge so a pixel arriving with the frame edge already sees the new value in S2.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_vs_prev_q <= 1'b0;
      atmo_q      <= '0;
      a_ok_q      <= 1'b0;
      s1_sync_q   <= '0;
      s1_mag_q    <= '0;
    end else begin
      d_vs_prev_q <= d_sync.vs;
      if (fe) begin
        atmo_q <= atmo;
        a_ok_q <= 1'b1;
      end
      s1_sync_q <= d_sync;
      s1_mag_q  <= mag_d;
    end
  end

  logic signed [13:0] r;
  logic               clip_hi;
  logic               clip_lo;
  logic               pix_act;
  logic [PIX_W-1:0]   pix_d;

  always_comb begin
    if (s1_sync_q.sign) r = $signed({6'd0, atmo_q}) - $signed({2'd0, s1_mag_q});
    else                r = $signed({6'd0, atmo_q}) + $signed({2'd0, s1_mag_q});
    clip_hi = (r > 14'sd255);
    clip_lo = (r < 14'sd0);
    pix_act = s1_sync_q.de & a_ok_q;
    pix_d   = '0;
    if (pix_act) begin
      if (clip_hi)       pix_d = '1;
      else if (!clip_lo) pix_d = r[PIX_W-1:0];
    end
  end

  logic [PIX_W-1:0] out_pix_q;
  logic             out_de_q;
  logic             out_hs_q;
  logic             out_vs_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_pix_q <= '0;
      out_de_q  <= 1'b0;
      out_hs_q  <= 1'b0;
      out_vs_q  <= 1'b0;
    end else begin
      out_pix_q <= pix_d;
      out_de_q  <= s1_sync_q.de;
      out_hs_q  <= s1_sync_q.hs;
      out_vs_q  <= s1_sync_q.vs;
    end
  end

  assign out_pix   = out_pix_q;
  assign out_de    = out_de_q;
  assign out_hsync = out_hs_q;
  assign out_vsync = out_vs_q;

`ifdef DEFOG_RECOVER_STAT_EN
  logic                  s1_fe_q;
  logic                  clip_ev;
  logic [CLIP_CNT_W-1:0] clip_cnt_q;
  logic [CLIP_CNT_W-1:0] clip_cnt_d;
  logic [CLIP_CNT_W-1:0] clip_frame_q;
  logic                  clip_vld_q;

  // The frame-edge pixel's own clip opens the new frame's count.
  always_comb begin
    clip_ev    = pix_act & (clip_hi | clip_lo);
    clip_cnt_d = clip_cnt_q;
    if (s1_fe_q)                         clip_cnt_d = CLIP_CNT_W'(clip_ev);
    else if (clip_ev && clip_cnt_q != '1) clip_cnt_d = clip_cnt_q + CLIP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_fe_q      <= 1'b0;
      clip_cnt_q   <= '0;
      clip_frame_q <= '0;
      clip_vld_q   <= 1'b0;
    end else begin
      s1_fe_q    <= fe;
      clip_cnt_q <= clip_cnt_d;
      clip_vld_q <= s1_fe_q;
      if (s1_fe_q) clip_frame_q <= clip_cnt_q;
    end
  end

  assign clip_frame = clip_frame_q;
  assign clip_vld   = clip_vld_q;
`else
  assign clip_frame = '0;
  assign clip_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_defog_recover.sv
// Bench for defog_recover: directed vector table, multi-cycle corner sequences and
// randomized frames checked against a frame-level arithmetic model.
module tb_defog_recover;
  localparam int MAXN = 320;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        in_de = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, in_sign = 1'b0;
  logic [7:0]  atmo = 8'd0, quotient = 8'd0;
  logic [7:0]  out_pix;
  logic        out_de, out_hsync, out_vsync;
  logic [15:0] clip_frame;
  logic        clip_vld;

  defog_recover dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_de      (in_de),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_sign    (in_sign),
    .atmo       (atmo),
    .quotient   (quotient),
    .out_pix    (out_pix),
    .out_de     (out_de),
    .out_hsync  (out_hsync),
    .out_vsync  (out_vsync),
    .clip_frame (clip_frame),
    .clip_vld   (clip_vld)
  );

  always #5 clk = ~clk;

  // Per-pixel stimulus: s_q[k] is the quotient belonging to input pixel k.
  bit s_de[MAXN], s_hs[MAXN], s_vs[MAXN], s_sign[MAXN];
  int s_q[MAXN], s_atmo[MAXN];
  // Captured outputs, indexed by the input pixel they belong to.
  int o_pix[MAXN], o_cf[MAXN];
  bit o_de[MAXN], o_hs[MAXN], o_vs[MAXN], o_cv[MAXN];

  int n_tests = 0;
  int n_fail  = 0;
  int g_ncap;
  int g_first_de;

  typedef struct {
    int atmo;
    int q;
    bit sign;
    bit de;
    int pos;
    int exp_pix;
  } vec_t;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      s_de[i] = 0; s_hs[i] = 0; s_vs[i] = 0; s_sign[i] = 0;
      s_q[i] = 0; s_atmo[i] = 0;
    end
  endtask

  // Resets the DUT (checking the reset state), then streams ncyc input cycles.
  task automatic run_segment(input int ncyc);
    int pre;
    int act;
    nrst = 1'b0;
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0; in_sign = 1'b0;
    atmo = 8'd0; quotient = 8'd0;
    #1;
    act = int'(out_pix) + int'(out_de) + int'(out_hsync) + int'(out_vsync)
        + int'(clip_frame) + int'(clip_vld);
    chk(act == 0, "reset_outputs", act, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    pre = 0;
    g_first_de = -1;
    for (int t = 0; t <= ncyc; t++) begin
      if (out_de === 1'b1 && g_first_de < 0) g_first_de = t;
      if (t < 10) begin
        if (out_pix != 0 || out_de || out_hsync || out_vsync || clip_vld || clip_frame != 0)
          pre = 1;
      end else begin
        o_pix[t-10] = int'(out_pix);
        o_de[t-10]  = out_de;
        o_hs[t-10]  = out_hsync;
        o_vs[t-10]  = out_vsync;
        o_cf[t-10]  = int'(clip_frame);
        o_cv[t-10]  = clip_vld;
      end
      if (t == ncyc) break;
      in_de    = s_de[t];
      in_hsync = s_hs[t];
      in_vsync = s_vs[t];
      in_sign  = s_sign[t];
      atmo     = 8'(s_atmo[t]);
      quotient = (t >= 8) ? 8'(s_q[t-8]) : 8'hA5;
      @(negedge clk);
    end
    g_ncap = ncyc - 9;
    chk(pre == 0, "quiet_after_reset", pre, 0);
  endtask

  // Frame-level model: A is whatever atmo shows when the frame edge reaches the
  // divider output; pixels before the first frame edge are black.
  task automatic check_model(input string tag);
    bit valid, vprev, fe, clip, ecv;
    int a, cnt, cf, mag, r, ep;
    valid = 0; vprev = 0; a = 0; cnt = 0; cf = 0;
    for (int k = 0; k < g_ncap; k++) begin
      fe = s_vs[k] && !vprev;
      vprev = s_vs[k];
      ecv = 0; clip = 0; ep = 0;
      if (fe) begin
        a = s_atmo[k+8];
        valid = 1;
      end
      if (s_de[k] && valid) begin
        mag = (s_q[k] * 255) / 16;
        if (mag > 4095) mag = 4095;
        r = s_sign[k] ? a - mag : a + mag;
        if (r > 255) begin ep = 255; clip = 1; end
        else if (r < 0) begin ep = 0; clip = 1; end
        else ep = r;
      end
`ifdef DEFOG_RECOVER_STAT_EN
      if (fe) begin
        cf = cnt; ecv = 1; cnt = clip ? 1 : 0;
      end else if (clip && cnt < 65535) begin
        cnt++;
      end
`endif
      chk(o_pix[k] == ep, $sformatf("%s_pix[%0d]", tag, k), o_pix[k], ep);
      chk({o_de[k], o_hs[k], o_vs[k]} == {s_de[k], s_hs[k], s_vs[k]},
          $sformatf("%s_sync[%0d]", tag, k),
          int'({o_de[k], o_hs[k], o_vs[k]}), int'({s_de[k], s_hs[k], s_vs[k]}));
      chk(o_cf[k] == cf && o_cv[k] == ecv, $sformatf("%s_stat[%0d]", tag, k),
          o_cf[k] * 2 + int'(o_cv[k]), cf * 2 + int'(ecv));
    end
  endtask

  initial begin
    vec_t vt[13];
    int   cnt_cv;
    int   a_cur, period, off;

    vt[0]  = '{150,   4, 1'b0, 1'b1, 0, 213};
    vt[1]  = '{150,   4, 1'b1, 1'b1, 0,  87};
    vt[2]  = '{200,  32, 1'b0, 1'b1, 2, 255};
    vt[3]  = '{ 20,   8, 1'b1, 1'b1, 2,   0};
    vt[4]  = '{150,   0, 1'b0, 1'b1, 2, 150};
    vt[5]  = '{ 77,   0, 1'b1, 1'b1, 0,  77};
    vt[6]  = '{100, 255, 1'b0, 1'b0, 2,   0};
    vt[7]  = '{  0,   1, 1'b0, 1'b1, 2,  15};
    vt[8]  = '{255, 255, 1'b1, 1'b1, 0,   0};
    vt[9]  = '{255,   1, 1'b0, 1'b1, 1, 255};
    vt[10] = '{100,  16, 1'b1, 1'b1, 2,   0};
    vt[11] = '{255,  16, 1'b1, 1'b1, 2,   0};
    vt[12] = '{  0,  16, 1'b0, 1'b1, 2, 255};

    @(negedge clk);

    // One pixel per frame, frame edge at pixel 0.
    for (int i = 0; i < 13; i++) begin
      clear_stim();
      s_vs[0] = 1; s_vs[1] = 1;
      for (int c = 0; c < MAXN; c++) s_atmo[c] = vt[i].atmo;
      s_de[vt[i].pos]   = vt[i].de;
      s_q[vt[i].pos]    = vt[i].q;
      s_sign[vt[i].pos] = vt[i].sign;
      run_segment(24);
      chk(o_pix[vt[i].pos] == vt[i].exp_pix, $sformatf("vec%0d", i),
          o_pix[vt[i].pos], vt[i].exp_pix);
      check_model($sformatf("vec%0d", i));
    end

    // atmo changes mid-frame; takes effect only at the next frame edge.
    clear_stim();
    for (int c = 0; c < 70; c++) begin
      s_de[c] = 1;
      s_atmo[c] = (c < 20) ? 100 : 180;
    end
    s_vs[5] = 1; s_vs[6] = 1; s_vs[40] = 1; s_vs[41] = 1;
    run_segment(70);
    chk(g_first_de == 10, "de_latency", g_first_de, 10);
    chk(o_pix[2] == 0, "atmo_before_fe", o_pix[2], 0);
    chk(o_pix[5] == 100, "atmo_fe_pixel", o_pix[5], 100);
    chk(o_pix[39] == 100, "atmo_hold_old", o_pix[39], 100);
    chk(o_pix[40] == 180, "atmo_next_fe", o_pix[40], 180);
    chk(o_pix[55] == 180, "atmo_new", o_pix[55], 180);
    check_model("atmo");

    // de low with full-scale quotient; syncs still delayed exactly.
    clear_stim();
    for (int c = 0; c < 30; c++) begin
      s_q[c] = 255;
      s_atmo[c] = 100;
    end
    s_vs[0] = 1; s_vs[1] = 1; s_hs[5] = 1; s_hs[12] = 1;
    run_segment(30);
    chk({o_hs[4], o_hs[5], o_hs[6]} == 3'b010, "hs_delay",
        int'({o_hs[4], o_hs[5], o_hs[6]}), 2);
    chk({o_vs[0], o_vs[1], o_vs[2]} == 3'b110, "vs_delay",
        int'({o_vs[0], o_vs[1], o_vs[2]}), 6);
    check_model("nodata");

    // Three clipping pixels, then a frame whose edge pixel clips.
    clear_stim();
    for (int c = 0; c < 60; c++) s_atmo[c] = 200;
    s_vs[0] = 1; s_vs[1] = 1; s_vs[20] = 1; s_vs[21] = 1; s_vs[40] = 1; s_vs[41] = 1;
    for (int c = 2; c <= 4; c++) begin s_de[c] = 1; s_q[c] = 32; end
    s_de[5] = 1; s_q[5] = 0;
    s_de[20] = 1; s_q[20] = 32;
    s_de[25] = 1; s_q[25] = 0;
    run_segment(60);
    cnt_cv = 0;
    for (int k = 0; k < g_ncap; k++) cnt_cv += int'(o_cv[k]);
`ifdef DEFOG_RECOVER_STAT_EN
    chk(cnt_cv == 3, "clip_vld_pulses", cnt_cv, 3);
    chk(o_cv[20] == 1 && o_cf[20] == 3, "clip_frame_3", o_cf[20], 3);
    chk(o_cv[21] == 0, "clip_vld_one_cycle", int'(o_cv[21]), 0);
    chk(o_cf[40] == 1, "clip_restart", o_cf[40], 1);
`else
    chk(cnt_cv == 0, "clip_vld_absent", cnt_cv, 0);
`endif
    chk(o_pix[4] == 255, "clip_pix", o_pix[4], 255);
    check_model("stats");

    // Randomized frames; each segment is cut off mid-stream by the next reset.
    for (int seg = 0; seg < 4; seg++) begin
      clear_stim();
      period = $urandom_range(30, 80);
      off    = $urandom_range(0, 29);
      a_cur  = $urandom_range(0, 255);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 19) == 0) a_cur = $urandom_range(0, 255);
        s_atmo[c] = a_cur;
        s_de[c]   = ($urandom_range(0, 3) != 0);
        s_hs[c]   = ($urandom_range(0, 7) == 0);
        s_vs[c]   = (((c + off) % period) < 2);
        s_sign[c] = ($urandom_range(0, 1) == 1);
        s_q[c]    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
      end
      run_segment(300);
      check_model($sformatf("rand%0d", seg));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
